// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt/trap controller: CSR map, cause codes,
// controller FSM encoding and the decoder state values the controller reacts to.
package irq_pkg;

    localparam logic [1:0] CSR_STATUS  = 2'd0;
    localparam logic [1:0] CSR_MASK    = 2'd1;
    localparam logic [1:0] CSR_PENDING = 2'd2;
    localparam logic [1:0] CSR_CAUSE   = 2'd3;

    localparam logic [3:0] CAUSE_SYSCALL = 4'd8;
    localparam logic [3:0] CAUSE_FAULT   = 4'd9;

    localparam logic [3:0] TRAP_ENTRY = 4'd0;
    localparam logic [3:0] EXECM      = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_FLT  = 2'd2,
        ST_TAKE = 2'd3
    } irq_state_t;

    // Offset of the handler entry from the vector base for a given cause.
    function automatic logic [15:0] vec_offset(input logic [3:0] c);
        if (c == CAUSE_SYSCALL)
            return 16'd16;
        else if (c == CAUSE_FAULT)
            return 16'd18;
        else
            return {11'b0, c, 1'b0};
    endfunction

endpackage

// File: rtl/irq_sync.sv
// One interrupt line: two-flop synchroniser followed by a rising-edge detector.
module irq_sync
    import irq_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic irq_in,
    output logic rise
);

    logic sync_1;
    logic sync_2;
    logic sync_prev;

    // Metastability filter, then one delayed copy for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1    <= 1'b0;
            sync_2    <= 1'b0;
            sync_prev <= 1'b0;
        end else begin
            sync_1    <= irq_in;
            sync_2    <= sync_1;
            sync_prev <= sync_2;
        end
    end

    assign rise = sync_2 & ~sync_prev;

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt/trap controller feeding irq_r/fault_r to the microcode decoder and
// sequencing trap entry (vector, cause, mode save) and return.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no request outstanding; watch fault, eligible IRQs, SYSCALL
// PEND    | irq_r raised, waiting for decoder trap entry (state 0)
// FLT     | fault_r raised, waiting for decoder trap entry (state 0)
// TAKE    | one-cycle entry: load vector, save ie/kmode, clear pending
//
// A fault or SYSCALL taken inside a handler overwrites pie/pkmode, so the
// interrupted context's mode is lost; software must avoid or tolerate this.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int          NIRQ     = 4,
    parameter logic [15:0] VEC_BASE = 16'h0010
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ-1:0] irq_in,
    input  logic            fault_in,
    input  logic [3:0]      state,
    input  logic            SYSCALL,
    input  logic            RETI,
    input  logic            csr_we,
    input  logic [1:0]      csr_addr,
    input  logic [15:0]     csr_wdata,
    output logic [15:0]     csr_rdata,
    output logic            irq_r,
    output logic            fault_r,
    output logic [15:0]     vector,
    output logic [3:0]      cause,
    output logic            kmode
);

    irq_state_t      fsm;
    logic [NIRQ-1:0] irq_rise;
    logic [NIRQ-1:0] pending;
    logic [NIRQ-1:0] mask;
    logic [NIRQ-1:0] eligible;
    logic [NIRQ-1:0] take_clr;
    logic [NIRQ-1:0] csr_clr;
    logic [3:0]      win_idx;
    logic            ie;
    logic            pie;
    logic            pkmode;
    logic            wr_status;
    logic            wr_mask;
    logic            wr_pending;
    logic            take_irq;
    logic            reti_ok;
    logic            unused_wdata;

    for (genvar g = 0; g < NIRQ; g++) begin : g_sync
        irq_sync u_sync (
            .clk    (clk),
            .reset  (reset),
            .irq_in (irq_in[g]),
            .rise   (irq_rise[g])
        );
    end

    assign wr_status  = csr_we && (csr_addr == CSR_STATUS) && kmode;
    assign wr_mask    = csr_we && (csr_addr == CSR_MASK) && kmode;
    assign wr_pending = csr_we && (csr_addr == CSR_PENDING);
    assign eligible   = pending & mask & {NIRQ{ie}};
    assign take_irq   = (fsm == ST_TAKE) && (cause < 4'(NIRQ));
    assign reti_ok    = RETI && (state == EXECM) && (fsm != ST_TAKE);
    assign csr_clr    = wr_pending ? csr_wdata[NIRQ-1:0] : '0;
    assign unused_wdata = ^csr_wdata;

    // Lowest-index eligible line wins
    always_comb begin
        win_idx = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (eligible[i])
                win_idx = 4'(i);
        end
    end

    // One-hot clear for the line being taken
    always_comb begin
        take_clr = '0;
        for (int i = 0; i < NIRQ; i++) begin
            take_clr[i] = take_irq && (cause == 4'(i));
        end
    end

    // Pending: new edges win over same-cycle clears
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pending <= '0;
        else
            pending <= (pending & ~(csr_clr | take_clr)) | irq_rise;
    end

    // Mask register, kernel-writable only
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            mask <= '0;
        else if (wr_mask)
            mask <= csr_wdata[NIRQ-1:0];
    end

    // Trap sequencer; TAKE overrides CSR and RETI updates of the mode bits
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm     <= ST_IDLE;
            ie      <= 1'b0;
            pie     <= 1'b0;
            kmode   <= 1'b1;
            pkmode  <= 1'b1;
            cause   <= '0;
            vector  <= VEC_BASE;
            irq_r   <= 1'b0;
            fault_r <= 1'b0;
        end else begin
            if (wr_status) begin
                kmode  <= csr_wdata[3];
                pkmode <= csr_wdata[2];
                ie     <= csr_wdata[1];
                pie    <= csr_wdata[0];
            end
            if (reti_ok) begin
                ie    <= pie;
                kmode <= pkmode;
            end
            case (fsm)
                ST_IDLE: begin
                    if (fault_in) begin
                        fault_r <= 1'b1;
                        fsm     <= ST_FLT;
                    end else if (eligible != '0) begin
                        irq_r <= 1'b1;
                        fsm   <= ST_PEND;
                    end else if (SYSCALL && (state == EXECM)) begin
                        cause <= CAUSE_SYSCALL;
                        fsm   <= ST_TAKE;
                    end
                end
                ST_PEND: begin
                    if (fault_in) begin
                        irq_r   <= 1'b0;
                        fault_r <= 1'b1;
                        fsm     <= ST_FLT;
                    end else if (eligible == '0) begin
                        irq_r <= 1'b0;
                        fsm   <= ST_IDLE;
                    end else if (state == TRAP_ENTRY) begin
                        irq_r <= 1'b0;
                        cause <= win_idx;
                        fsm   <= ST_TAKE;
                    end
                end
                ST_FLT: begin
                    if (state == TRAP_ENTRY) begin
                        fault_r <= 1'b0;
                        cause   <= CAUSE_FAULT;
                        fsm     <= ST_TAKE;
                    end
                end
                ST_TAKE: begin
                    vector <= VEC_BASE + vec_offset(cause);
                    pie    <= ie;
                    ie     <= 1'b0;
                    pkmode <= kmode;
                    kmode  <= 1'b1;
                    fsm    <= ST_IDLE;
                end
                default: fsm <= ST_IDLE;
            endcase
        end
    end

    // CSR read mux
    always_comb begin
        csr_rdata = '0;
        case (csr_addr)
            CSR_STATUS:  csr_rdata = {12'b0, kmode, pkmode, ie, pie};
            CSR_MASK:    csr_rdata = 16'(mask);
            CSR_PENDING: csr_rdata = 16'(pending);
            CSR_CAUSE:   csr_rdata = {12'b0, cause};
            default:     csr_rdata = '0;
        endcase
    end

endmodule
